// File: rtl/pixel_stream_arbiter.sv
// pixel_stream_arbiter
//   Round-robin arbiter that shares one registered RGB pixel stream between
//   NUM_SRC valid/ready pixel sources. A grant lasts until the granted source
//   sends its last pixel or MAX_BURST pixels have been taken, whichever comes
//   first. Each forwarded pixel is tagged with the index of its source.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   s_valid  in   [NUM_SRC]        per-source pixel valid
//   s_pixel  in   [NUM_SRC*PIX_W]  source i pixel at [i*PIX_W +: PIX_W]
//   s_last   in   [NUM_SRC]        per-source end-of-packet flag
//   s_ready  out  [NUM_SRC]        per-source accept, at most one bit high
//   m_valid  out                   output pixel valid
//   m_pixel  out  [PIX_W]          output pixel {R,G,B}
//   m_last   out                   s_last of the forwarded pixel
//   m_src    out  [clog2(NUM_SRC)] source index of m_pixel
//   m_ready  in                    downstream accept
//   busy     out                   high while a grant is active
module pixel_stream_arbiter #(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned PIX_W     = 24,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         s_valid,
    input  logic [NUM_SRC*PIX_W-1:0]   s_pixel,
    input  logic [NUM_SRC-1:0]         s_last,
    output logic [NUM_SRC-1:0]         s_ready,
    output logic                       m_valid,
    output logic [PIX_W-1:0]           m_pixel,
    output logic                       m_last,
    output logic [$clog2(NUM_SRC)-1:0] m_src,
    input  logic                       m_ready,
    output logic                       busy
);

    localparam int unsigned SRC_W  = $clog2(NUM_SRC);
    // One extra count value so the increment on the final beat cannot wrap.
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [SRC_W-1:0]  LAST_SRC  = SRC_W'(NUM_SRC - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state, state_nxt;
    logic [SRC_W-1:0]   gnt, gnt_nxt;
    logic [SRC_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [BEAT_W-1:0]  beat_cnt, beat_nxt;

    logic [SRC_W-1:0]   pick;
    logic [SRC_W-1:0]   cand;
    logic               found;
    logic               out_free;
    logic               xfer;
    logic               pkt_end;
    logic [PIX_W-1:0]   sel_pixel;
    logic [PIX_W-1:0]   pix_arr [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign pix_arr[g] = s_pixel[g*PIX_W +: PIX_W];
    end

    // First requesting source at or after rr_ptr, wrapping past NUM_SRC-1.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = SRC_W'((32'(rr_ptr) + i) % NUM_SRC);
            if (!found && s_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign out_free  = !m_valid || m_ready;
    assign xfer      = (state == GRANT) && s_valid[gnt] && out_free;
    assign pkt_end   = s_last[gnt] || (beat_cnt == LAST_BEAT);
    assign sel_pixel = pix_arr[gnt];
    assign busy      = (state == GRANT);

    always_comb begin
        s_ready = '0;
        if (state == GRANT) begin
            s_ready[gnt] = out_free;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        beat_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    beat_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    beat_nxt = beat_cnt + 1'b1;
                    // Burst cutoff rotates the grant but leaves m_last alone.
                    if (pkt_end) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = (gnt == LAST_SRC) ? '0 : gnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pixel <= '0;
            m_last  <= 1'b0;
            m_src   <= '0;
        end else if (xfer) begin
            m_valid <= 1'b1;
            m_pixel <= sel_pixel;
            m_last  <= s_last[gnt];
            m_src   <= gnt;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
